// File: rtl/ase_pcie_ss_rd_tag_tracker.sv
// -----------------------------------------------------------------------------
// ase_pcie_ss_rd_tag_tracker
//
// DMA read-tag allocator and completion tracker for the ASE AXI-S PCIe SS
// emulation. It grants read tags up to NUM_TAGS outstanding and records the
// bytes still owed per tag. Split completions are checked against the read
// completion boundary (RCB), and a tag is retired when its last byte returns.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   alloc_valid       request for a tag
//   alloc_len         requested length in bytes
//   alloc_ready       a free tag exists
//   alloc_tag         tag granted when alloc_valid && alloc_ready
//   alloc_err         one-cycle pulse: last accepted request had illegal length
//   cpl_valid         completion arrives (always accepted)
//   cpl_tag, cpl_len  completion tag and payload bytes
//   cpl_done          one-cycle pulse: tag fully completed and freed
//   cpl_done_tag      tag retired with cpl_done
//   cpl_err           one-cycle pulse: illegal completion
//   num_outstanding   count of busy tags (0..NUM_TAGS)
// -----------------------------------------------------------------------------
module ase_pcie_ss_rd_tag_tracker #(
   parameter int NUM_TAGS         = 256,
   parameter int TAG_W            = $clog2(NUM_TAGS),
   parameter int LEN_W            = 13,
   parameter int MAX_RD_REQ_BYTES = 4096,
   parameter int RCB_BYTES        = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_valid,
   input  logic [LEN_W-1:0] alloc_len,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             alloc_err,
   input  logic             cpl_valid,
   input  logic [TAG_W-1:0] cpl_tag,
   input  logic [LEN_W-1:0] cpl_len,
   output logic             cpl_done,
   output logic [TAG_W-1:0] cpl_done_tag,
   output logic             cpl_err,
   output logic [TAG_W:0]   num_outstanding
);

   localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W+1)'(MAX_RD_REQ_BYTES);
   localparam logic [LEN_W-1:0] RCB_MASK = LEN_W'(RCB_BYTES - 1);

   // Reset synchroniser: assertion is immediate through rst_n, deassertion
   // reaches the state logic two clocks later so no flop leaves reset on an
   // edge that races the external release.
   logic [1:0] rst_sync_q;
   logic       run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign run = rst_sync_q[1];

   // State
   logic [NUM_TAGS-1:0] busy_q, busy_d;
   logic [TAG_W:0]      count_q, count_d;
   logic                alloc_err_q, alloc_err_d;
   logic                cpl_done_q, cpl_done_d;
   logic [TAG_W-1:0]    cpl_done_tag_q, cpl_done_tag_d;
   logic                cpl_err_q, cpl_err_d;
   logic [LEN_W-1:0]    remaining_q [NUM_TAGS];

   // Free-tag search: lowest-index clear bit of the registered busy vector.
   // Scanning downward lets the last hit (lowest index) win.
   logic [TAG_W-1:0] free_tag;
   logic             any_free;

   always_comb begin
      free_tag = '0;
      any_free = 1'b0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_tag = TAG_W'(i);
            any_free = 1'b1;
         end
      end
   end

   // Ready is held low while the synchronised reset is still active so the
   // block grants nothing until its state is valid.
   assign alloc_ready = run && any_free;
   assign alloc_tag   = free_tag;

   // Allocation decode
   logic alloc_fire;
   logic alloc_len_ok;
   logic alloc_set;

   assign alloc_fire   = alloc_valid && alloc_ready;
   assign alloc_len_ok = (alloc_len != '0) && ({1'b0, alloc_len} <= MAX_LEN);
   assign alloc_set    = alloc_fire && alloc_len_ok;

   // Completion decode, all against pre-edge state
   logic             cpl_act;
   logic             cpl_busy;
   logic [LEN_W-1:0] cpl_rem;
   logic             e1_idle;
   logic             e2_abort;
   logic             e3_rcb;
   logic             cpl_ok;
   logic             cpl_last;
   logic             tag_free;
   logic [LEN_W-1:0] rem_next;

   assign cpl_act  = cpl_valid && run;
   assign cpl_busy = busy_q[cpl_tag];
   assign cpl_rem  = remaining_q[cpl_tag];

   assign e1_idle  = cpl_act && !cpl_busy;
   assign e2_abort = cpl_act && cpl_busy && ((cpl_len == '0) || (cpl_len > cpl_rem));
   // Only a non-final piece must end on an RCB boundary; the last piece may
   // be any length that exactly drains the tag.
   assign e3_rcb   = cpl_act && cpl_busy && !e2_abort && (cpl_len < cpl_rem)
                     && ((cpl_len & RCB_MASK) != '0);
   assign cpl_ok   = cpl_act && cpl_busy && !e2_abort && !e3_rcb;

   // Subtraction is only used when cpl_len <= remaining, so it never wraps.
   assign rem_next = cpl_rem - cpl_len;
   assign cpl_last = cpl_ok && (rem_next == '0);
   assign tag_free = cpl_last || e2_abort;

   // Next-state. The allocated tag is clear in busy_q while a freed tag is
   // set in busy_q, so the two updates never touch the same bit.
   always_comb begin
      busy_d         = busy_q;
      count_d        = count_q;
      alloc_err_d    = 1'b0;
      cpl_done_d     = 1'b0;
      cpl_done_tag_d = cpl_done_tag_q;
      cpl_err_d      = 1'b0;

      if (alloc_set) begin
         busy_d[alloc_tag] = 1'b1;
      end
      if (tag_free) begin
         busy_d[cpl_tag] = 1'b0;
      end

      // Simultaneous +1 and -1 cancel; the count stays within 0..NUM_TAGS
      // because grants require a clear bit and frees require a set bit.
      case ({alloc_set, tag_free})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      alloc_err_d = alloc_fire && !alloc_len_ok;
      cpl_err_d   = e1_idle || e2_abort || e3_rcb;

      if (cpl_last) begin
         cpl_done_d     = 1'b1;
         cpl_done_tag_d = cpl_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q         <= '0;
         count_q        <= '0;
         alloc_err_q    <= 1'b0;
         cpl_done_q     <= 1'b0;
         cpl_done_tag_q <= '0;
         cpl_err_q      <= 1'b0;
      end else if (!run) begin
         busy_q         <= '0;
         count_q        <= '0;
         alloc_err_q    <= 1'b0;
         cpl_done_q     <= 1'b0;
         cpl_done_tag_q <= '0;
         cpl_err_q      <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         count_q        <= count_d;
         alloc_err_q    <= alloc_err_d;
         cpl_done_q     <= cpl_done_d;
         cpl_done_tag_q <= cpl_done_tag_d;
         cpl_err_q      <= cpl_err_d;
      end
   end

   // Byte counters are pure data: valid only while the matching busy bit is
   // set, and always rewritten on allocation, so they carry no reset.
   always_ff @(posedge clk) begin
      if (alloc_set) begin
         remaining_q[alloc_tag] <= alloc_len;
      end
      if (cpl_ok && !cpl_last) begin
         remaining_q[cpl_tag] <= rem_next;
      end
   end

   assign alloc_err       = alloc_err_q;
   assign cpl_done        = cpl_done_q;
   assign cpl_done_tag    = cpl_done_tag_q;
   assign cpl_err         = cpl_err_q;
   assign num_outstanding = count_q;

endmodule

// File: tb/tb_ase_pcie_ss_rd_tag_tracker.sv
module tb_ase_pcie_ss_rd_tag_tracker;

   localparam int NUM_TAGS = 256;
   localparam int TAG_W    = 8;
   localparam int LEN_W    = 13;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             alloc_valid;
   logic [LEN_W-1:0] alloc_len;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             alloc_err;
   logic             cpl_valid;
   logic [TAG_W-1:0] cpl_tag;
   logic [LEN_W-1:0] cpl_len;
   logic             cpl_done;
   logic [TAG_W-1:0] cpl_done_tag;
   logic             cpl_err;
   logic [TAG_W:0]   num_outstanding;

   int n_chk = 0;
   int n_err = 0;

   ase_pcie_ss_rd_tag_tracker #(
      .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W), .LEN_W(LEN_W),
      .MAX_RD_REQ_BYTES(4096), .RCB_BYTES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_len(alloc_len),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .alloc_err(alloc_err),
      .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_len(cpl_len),
      .cpl_done(cpl_done), .cpl_done_tag(cpl_done_tag), .cpl_err(cpl_err),
      .num_outstanding(num_outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input int len);
      alloc_valid = 1'b1;
      alloc_len   = LEN_W'(len);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cpl(input int t, input int len);
      cpl_valid = 1'b1;
      cpl_tag   = TAG_W'(t);
      cpl_len   = LEN_W'(len);
      tick();
      cpl_valid = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 8 && !alloc_ready; i++) tick();
      chk(tag, alloc_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      alloc_valid = 1'b0;
      alloc_len   = '0;
      cpl_valid   = 1'b0;
      cpl_tag     = '0;
      cpl_len     = '0;
      repeat (3) tick();
      chk("rst_num", num_outstanding, 0);
      chk("rst_ready", alloc_ready, 0);
      chk("rst_done", cpl_done, 0);
      chk("rst_err", cpl_err, 0);
      chk("rst_aerr", alloc_err, 0);
      rst_n = 1'b1;
      wait_ready("ready_after_rst");

      // 1: basic allocation and split completion
      for (int i = 0; i < 3; i++) begin
         chk("t1_tag", alloc_tag, i);
         do_alloc(256);
         chk("t1_aerr", alloc_err, 0);
      end
      chk("t1_num3", num_outstanding, 3);
      do_cpl(1, 64);
      chk("t1_part_done", cpl_done, 0);
      chk("t1_part_err", cpl_err, 0);
      chk("t1_part_num", num_outstanding, 3);
      do_cpl(1, 192);
      chk("t1_done", cpl_done, 1);
      chk("t1_done_tag", cpl_done_tag, 1);
      chk("t1_num2", num_outstanding, 2);
      tick();
      chk("t1_done_pulse", cpl_done, 0);
      chk("t1_next_tag", alloc_tag, 1);
      do_alloc(256);
      chk("t1_num_re", num_outstanding, 3);

      // 2: fill every tag, then free and re-grant in the following cycle
      alloc_valid = 1'b1;
      alloc_len   = LEN_W'(64);
      for (int i = 3; i < NUM_TAGS; i++) begin
         chk("t2_fill_tag", alloc_tag, i);
         tick();
      end
      chk("t2_full_ready", alloc_ready, 0);
      chk("t2_full_num", num_outstanding, 256);
      chk("t2_full_tag", alloc_tag, 0);
      cpl_valid = 1'b1;
      cpl_tag   = TAG_W'(7);
      cpl_len   = LEN_W'(64);
      tick();
      cpl_valid = 1'b0;
      chk("t2_done", cpl_done, 1);
      chk("t2_done_tag", cpl_done_tag, 7);
      chk("t2_no_grant_num", num_outstanding, 255);
      chk("t2_ready", alloc_ready, 1);
      chk("t2_tag7", alloc_tag, 7);
      tick();
      alloc_valid = 1'b0;
      chk("t2_regrant_num", num_outstanding, 256);
      chk("t2_regrant_ready", alloc_ready, 0);

      // 3: illegal lengths and the legal upper bound
      do_cpl(8, 64);
      do_cpl(9, 64);
      chk("t3_num", num_outstanding, 254);
      chk("t3_tag", alloc_tag, 8);
      do_alloc(0);
      chk("t3_len0_err", alloc_err, 1);
      chk("t3_len0_num", num_outstanding, 254);
      chk("t3_len0_tag", alloc_tag, 8);
      do_alloc(4097);
      chk("t3_len4097_err", alloc_err, 1);
      chk("t3_len4097_num", num_outstanding, 254);
      chk("t3_len4097_tag", alloc_tag, 8);
      do_alloc(4096);
      chk("t3_len4096_err", alloc_err, 0);
      chk("t3_len4096_num", num_outstanding, 255);
      chk("t3_len4096_tag", alloc_tag, 9);

      // 4: RCB violation keeps remaining; oversize completion aborts the tag
      do_cpl(0, 256);
      chk("t4_free0_done", cpl_done, 1);
      chk("t4_free0_tag", cpl_done_tag, 0);
      chk("t4_tag0", alloc_tag, 0);
      do_alloc(128);
      chk("t4_num", num_outstanding, 255);
      do_cpl(0, 40);
      chk("t4_e3_err", cpl_err, 1);
      chk("t4_e3_done", cpl_done, 0);
      chk("t4_e3_num", num_outstanding, 255);
      do_cpl(0, 128);
      chk("t4_rem_kept_done", cpl_done, 1);
      chk("t4_rem_kept_err", cpl_err, 0);
      chk("t4_rem_kept_num", num_outstanding, 254);
      do_alloc(128);
      do_cpl(0, 200);
      chk("t4_e2_err", cpl_err, 1);
      chk("t4_e2_done", cpl_done, 0);
      chk("t4_e2_num", num_outstanding, 254);
      chk("t4_e2_freed", alloc_tag, 0);

      // 5: idle-tag completion, and completion racing allocation of that tag
      do_cpl(5, 64);
      chk("t5_free5", cpl_done, 1);
      chk("t5_num", num_outstanding, 253);
      do_cpl(5, 64);
      chk("t5_e1_err", cpl_err, 1);
      chk("t5_e1_done", cpl_done, 0);
      chk("t5_e1_num", num_outstanding, 253);
      tick();
      chk("t5_err_pulse", cpl_err, 0);
      chk("t5_race_tag", alloc_tag, 0);
      alloc_valid = 1'b1;
      alloc_len   = LEN_W'(64);
      cpl_valid   = 1'b1;
      cpl_tag     = TAG_W'(0);
      cpl_len     = LEN_W'(64);
      tick();
      alloc_valid = 1'b0;
      cpl_valid   = 1'b0;
      chk("t5_race_err", cpl_err, 1);
      chk("t5_race_done", cpl_done, 0);
      chk("t5_race_num", num_outstanding, 254);
      chk("t5_race_next", alloc_tag, 5);
      do_cpl(0, 64);
      chk("t5_race_busy", cpl_done, 1);
      chk("t5_race_busy_tag", cpl_done_tag, 0);

      // 6: asynchronous reset with many tags busy and a pulse active
      do_cpl(10, 64);
      chk("t6_pre_done", cpl_done, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_done", cpl_done, 0);
      chk("t6_rst_done_tag", cpl_done_tag, 0);
      chk("t6_rst_err", cpl_err, 0);
      chk("t6_rst_aerr", alloc_err, 0);
      chk("t6_rst_num", num_outstanding, 0);
      chk("t6_rst_ready", alloc_ready, 0);
      chk("t6_rst_tag", alloc_tag, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_ready("t6_ready");
      chk("t6_tag0", alloc_tag, 0);
      chk("t6_no_done", cpl_done, 0);
      do_alloc(64);
      chk("t6_num1", num_outstanding, 1);
      chk("t6_tag1", alloc_tag, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
